wptr_full_ctrl: RTL

Write-side pointer and full-flag controller for the dual-clock FIFO in the CDC synchronizer. It lives entirely in the write clock domain and accepts push requests. It produces the binary write address and the Gray-coded write pointer that is exported to the read domain. It compares its own pointer against the read-domain Gray pointer, already brought across by the two-flop synchronizer, to generate registered full, almost-full, fill-level and overflow status.

---
 rtl/wptr_full_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full-flag controller for a dual-clock FIFO.
// Produces the binary RAM address, the Gray pointer for the read side, and registered fill status.
module wptr_full_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rgray_sync,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wgray,
  output logic              wr_accept,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] level_next;
  logic [ADDR_W:0] full_pattern;
  logic            full_next;
  logic            af_next;

  assign wr_accept  = wr_en & ~full;
  assign waddr      = wbin[ADDR_W-1:0];
  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wr_accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_pattern = {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]};
  assign full_next    = (wgray_next == full_pattern);

  for (genvar i = 0; i <= ADDR_W; i++) begin : g_rbin
    assign rbin[i] = ^rgray_sync[ADDR_W:i];
  end

  assign level_next = wbin_next - rbin;
  assign af_next    = (level_next >= AF_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      full        <= full_next;
      almost_full <= af_next;
      wlevel      <= level_next;
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

endmodule
